demux_1_4_stream: RTL

//  Inverse of the 4:1 selector: one valid/ready input stream, routed by a 2-bit

---
 rtl/demux_1_4_stream.sv | 108 ++++++++++
 1 files changed

// File: rtl/demux_1_4_stream.sv
// 1:4 stream demultiplexer: routes one valid/ready word to one of four one-entry channel registers by in_sel.
// Latency 1 cycle from input transfer to out_valid; each channel sustains one word per cycle when drained.
// Backpressure is per channel: a stalled channel blocks only words addressed to it (in_ready follows in_sel).
// Optional build macro DEMUX_1_4_CNT_EN adds 8-bit wrapping per-channel transfer counters cnt0..cnt3.

module demux_1_4_stream #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data0,
  output logic [W-1:0] out_data1,
  output logic [W-1:0] out_data2,
  output logic [W-1:0] out_data3
`ifdef DEMUX_1_4_CNT_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic [7:0]   cnt2,
  output logic [7:0]   cnt3
`endif
);

  // Per-channel occupancy flags and data registers.
  logic [3:0]          valid_q, valid_d;
  logic [3:0][W-1:0]   data_q, data_d;

  // Per-cycle handshake decode.
  logic                xfer;
  logic [3:0]          load;
  logic [3:0]          drain;

  // Input handshake: the addressed channel can take a word if it is empty or
  // is being drained this cycle; in_ready deliberately ignores in_valid.
  always_comb begin
    in_ready = !valid_q[in_sel] | out_ready[in_sel];
    xfer     = in_valid & in_ready;
    load     = '0;
    if (xfer) begin
      load[in_sel] = 1'b1;
    end
    drain    = valid_q & out_ready;
  end

  // Next-state: drain clears a channel, a load sets it; drain and load on the
  // same channel leave it full with the new word (no bubble).
  always_comb begin
    valid_d = (valid_q & ~drain) | load;
    data_d  = data_q;
    for (int k = 0; k < 4; k++) begin
      if (load[k]) begin
        data_d[k] = in_data;
      end
    end
  end

  // Channel registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef DEMUX_1_4_CNT_EN
  logic [3:0][7:0] cnt_q, cnt_d;

  // Count accepted words per channel; 8-bit wrap is intentional.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (load[k]) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule
